multi_ch_timer: RTL and testbench

Parametrised multi-channel trigger timer, the next generation of the team's single-channel delay counter. Each of CH independent channels waits for a trigger, then holds its counting-finished flag low for a selectable number of clock cycles. Adds per-channel delay modes: base, triple, externally loaded, and periodic auto-reload. Also adds abort, optional retrigger, a one-cycle done pulse, and an all-idle summary. Sits between control FSMs and the datapath elements they must wait on.

---
 rtl/multi_ch_timer.sv | 124 ++++++++++++
 tb/tb_multi_ch_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_timer.sv
// Multi-channel trigger timer: each channel holds cf low for a mode-selected
// number of cycles after a trigger, then pulses done for one cycle.
module multi_ch_timer #(
  parameter int CH     = 4,
  parameter int WIDTH  = 16,
  parameter int T_BASE = 5,
  parameter int RETRIG = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CH-1:0]      tr,
  input  logic [CH-1:0]      abort,
  input  logic [2*CH-1:0]    mode,
  input  logic [WIDTH-1:0]   ld_val,
  output logic [CH-1:0]      cf,
  output logic [CH-1:0]      done,
  output logic               all_idle
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("multi_ch_timer: CH must be in 1..32");
  end
  if (T_BASE < 1) begin : g_bad_tbase
    $error("multi_ch_timer: T_BASE must be at least 1");
  end
  if (WIDTH < 64 && ((64'(3 * T_BASE)) >> WIDTH) != 64'd0) begin : g_bad_width
    $error("multi_ch_timer: 3*T_BASE does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] D_BASE   = WIDTH'(T_BASE);
  localparam logic [WIDTH-1:0] D_TRIPLE = WIDTH'(3 * T_BASE);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           st, st_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] dly, dly_n;
    logic [WIDTH-1:0] d_res;
    logic             per, per_n;
    logic             done_q, done_n;
    logic [1:0]       m;

    assign m = mode[2*i +: 2];

    // Delay resolved from the live mode/ld_val; only latched on a (re)trigger.
    always_comb begin
      d_res = D_BASE;
      case (m)
        2'd0:    d_res = D_BASE;
        2'd1:    d_res = D_TRIPLE;
        2'd2:    d_res = (ld_val == '0) ? ONE : ld_val;
        default: d_res = D_BASE;
      endcase
    end

    always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      dly_n  = dly;
      per_n  = per;
      done_n = 1'b0;
      if (abort[i]) begin
        st_n  = IDLE;
        cnt_n = '0;
      end else begin
        case (st)
          IDLE: begin
            if (tr[i]) begin
              st_n  = RUN;
              dly_n = d_res;
              per_n = (m == 2'd3);
              cnt_n = d_res - ONE;
            end
          end
          RUN: begin
            // A retrigger reload takes priority over expiry, so no done pulse.
            if (tr[i] && (RETRIG != 0)) begin
              dly_n = d_res;
              per_n = (m == 2'd3);
              cnt_n = d_res - ONE;
            end else if (cnt != '0) begin
              cnt_n = cnt - ONE;
            end else begin
              done_n = 1'b1;
              if (per) begin
                cnt_n = dly - ONE;
              end else begin
                st_n = IDLE;
              end
            end
          end
          default: begin
            st_n  = IDLE;
            cnt_n = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st     <= IDLE;
        cnt    <= '0;
        dly    <= D_BASE;
        per    <= 1'b0;
        done_q <= 1'b0;
      end else begin
        st     <= st_n;
        cnt    <= cnt_n;
        dly    <= dly_n;
        per    <= per_n;
        done_q <= done_n;
      end
    end

    assign cf[i]   = (st == IDLE);
    assign done[i] = done_q;
  end

  assign all_idle = &cf;

endmodule

// File: tb/tb_multi_ch_timer.sv
// Directed bench for multi_ch_timer: one instance with RETRIG=1, one with RETRIG=0,
// both driven identically; per-edge expectations are queued and checked at negedge.
module tb_multi_ch_timer;
  localparam int CH     = 4;
  localparam int WIDTH  = 16;
  localparam int T_BASE = 5;
  localparam int W      = 2*CH + 1;
  localparam int NE     = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [CH-1:0]    tr;
  logic [CH-1:0]    abort;
  logic [2*CH-1:0]  mode;
  logic [WIDTH-1:0] ld_val;
  logic [CH-1:0]    cf_a, done_a, cf_b, done_b;
  logic             all_idle_a, all_idle_b;

  logic [W-1:0]     exp_qa[$];
  logic [W-1:0]     exp_qb[$];

  logic [CH-1:0]    ecf_a[NE];
  logic [CH-1:0]    edn_a[NE];
  logic [CH-1:0]    ecf_b[NE];
  logic [CH-1:0]    edn_b[NE];
  logic [CH-1:0]    s_tr[NE];
  logic [CH-1:0]    s_ab[NE];
  logic [2*CH-1:0]  s_mode[NE];
  logic [WIDTH-1:0] win_ld;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  multi_ch_timer #(.CH(CH), .WIDTH(WIDTH), .T_BASE(T_BASE), .RETRIG(1)) dut_a (
    .clk(clk), .reset(reset), .tr(tr), .abort(abort), .mode(mode), .ld_val(ld_val),
    .cf(cf_a), .done(done_a), .all_idle(all_idle_a)
  );

  multi_ch_timer #(.CH(CH), .WIDTH(WIDTH), .T_BASE(T_BASE), .RETRIG(0)) dut_b (
    .clk(clk), .reset(reset), .tr(tr), .abort(abort), .mode(mode), .ld_val(ld_val),
    .cf(cf_b), .done(done_b), .all_idle(all_idle_b)
  );

  task automatic check(input string tag, input int e, input logic [W-1:0] obs,
                       input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s edge %0d: observed {cf,done,all_idle}=%b expected %b", tag, e, obs, expv);
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < NE; k++) begin
      ecf_a[k]  = '1;
      edn_a[k]  = '0;
      ecf_b[k]  = '1;
      edn_b[k]  = '0;
      s_tr[k]   = '0;
      s_ab[k]   = '0;
      s_mode[k] = '0;
    end
    win_ld = '0;
  endtask

  // Channel ch is low after edges e0..e0+d-1; done (optional) after edge e0+d.
  // which[0] selects the RETRIG=1 instance, which[1] the RETRIG=0 instance.
  task automatic plan(input int ch, input int e0, input int d, input bit with_done,
                      input logic [1:0] which);
    for (int k = e0; k < e0 + d; k++) begin
      if (which[0]) ecf_a[k][ch] = 1'b0;
      if (which[1]) ecf_b[k][ch] = 1'b0;
    end
    if (with_done) begin
      if (which[0]) edn_a[e0+d][ch] = 1'b1;
      if (which[1]) edn_b[e0+d][ch] = 1'b1;
    end
  endtask

  task automatic run_window(input int n, input string tag);
    for (int e = 1; e <= n; e++) begin
      exp_qa.push_back({ecf_a[e], edn_a[e], &ecf_a[e]});
      exp_qb.push_back({ecf_b[e], edn_b[e], &ecf_b[e]});
    end
    for (int e = 1; e <= n; e++) begin
      tr     = s_tr[e];
      abort  = s_ab[e];
      mode   = s_mode[e];
      ld_val = win_ld;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_rt1"}, e, {cf_a, done_a, all_idle_a}, exp_qa.pop_front());
      check({tag, "_rt0"}, e, {cf_b, done_b, all_idle_b}, exp_qb.pop_front());
    end
    tr    = '0;
    abort = '0;
  endtask

  initial begin
    reset  = 1'b1;
    tr     = '0;
    abort  = '0;
    mode   = '0;
    ld_val = '0;
    #1;
    exp_qa.push_back({4'hf, 4'h0, 1'b1});
    exp_qb.push_back({4'hf, 4'h0, 1'b1});
    check("reset_rt1", 0, {cf_a, done_a, all_idle_a}, exp_qa.pop_front());
    check("reset_rt0", 0, {cf_b, done_b, all_idle_b}, exp_qb.pop_front());
    @(negedge clk);
    reset = 1'b0;

    // Mode 0 on ch0
    clear_plan();
    s_tr[2] = 4'b0001;
    plan(0, 2, T_BASE, 1'b1, 2'b11);
    run_window(10, "mode0");

    // Mode 1 on ch1 and mode 2 (ld_val=7) on ch2, same trigger edge
    clear_plan();
    win_ld = 16'd7;
    for (int k = 0; k < NE; k++) s_mode[k] = 8'b00_10_01_00;
    s_tr[1] = 4'b0110;
    plan(1, 1, 3*T_BASE, 1'b1, 2'b11);
    plan(2, 1, 7, 1'b1, 2'b11);
    run_window(18, "mode1_mode2");

    // ld_val=0 clamps to one cycle; back-to-back trigger while done is high
    clear_plan();
    win_ld = 16'd0;
    for (int k = 0; k < NE; k++) s_mode[k] = 8'b00_10_00_00;
    s_tr[1] = 4'b0100;
    s_tr[3] = 4'b0100;
    plan(2, 1, 1, 1'b1, 2'b11);
    plan(2, 3, 1, 1'b1, 2'b11);
    run_window(6, "ld_zero");

    // Periodic on ch3, mode changed mid-run, then abort
    clear_plan();
    for (int k = 0; k < NE; k++) s_mode[k] = (k < 4) ? 8'b11_00_00_00 : 8'h00;
    s_tr[1]  = 4'b1000;
    s_ab[14] = 4'b1000;
    plan(3, 1, T_BASE, 1'b1, 2'b11);
    plan(3, 6, T_BASE, 1'b1, 2'b11);
    plan(3, 11, 3, 1'b0, 2'b11);
    run_window(20, "periodic");

    // Retrigger 3 cycles into a run
    clear_plan();
    s_tr[1] = 4'b0001;
    s_tr[4] = 4'b0001;
    plan(0, 1, 3 + T_BASE, 1'b1, 2'b01);
    plan(0, 1, T_BASE, 1'b1, 2'b10);
    run_window(12, "retrig");

    // tr+abort collision in IDLE on ch1; retrigger on the expiry edge on ch0
    clear_plan();
    s_tr[1] = 4'b0010;
    s_ab[1] = 4'b0010;
    s_tr[3] = 4'b0001;
    s_tr[8] = 4'b0001;
    plan(0, 3, T_BASE + T_BASE, 1'b1, 2'b01);
    plan(0, 3, T_BASE, 1'b1, 2'b10);
    run_window(16, "collision");

    // All channels running, then asynchronous reset mid-cycle
    clear_plan();
    s_tr[1] = 4'b1111;
    plan(0, 1, 3, 1'b0, 2'b11);
    plan(1, 1, 3, 1'b0, 2'b11);
    plan(2, 1, 3, 1'b0, 2'b11);
    plan(3, 1, 3, 1'b0, 2'b11);
    run_window(3, "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    exp_qa.push_back({4'hf, 4'h0, 1'b1});
    exp_qb.push_back({4'hf, 4'h0, 1'b1});
    check("async_reset_rt1", 0, {cf_a, done_a, all_idle_a}, exp_qa.pop_front());
    check("async_reset_rt0", 0, {cf_b, done_b, all_idle_b}, exp_qb.pop_front());
    @(negedge clk);
    reset = 1'b0;

    // First trigger after release is honoured
    clear_plan();
    s_tr[1] = 4'b0001;
    plan(0, 1, T_BASE, 1'b1, 2'b11);
    run_window(8, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
